// File: rtl/mig_ui_responder.sv
// Memory-side stand-in for the DDR3 controller user interface: in-order command and
// write-data queues, a word array, a fixed-latency read pipeline, calibration delay and ready stalls.
module mig_ui_responder #(
  parameter int ADDR_WIDTH       = 29,
  parameter int APP_DATA_WIDTH   = 128,
  parameter int APP_MASK_WIDTH   = 16,
  parameter int MEM_DEPTH_LOG2   = 10,
  parameter int CALIB_CYCLES     = 64,
  parameter int RD_LATENCY       = 8,
  parameter int RDY_STALL_PERIOD = 0
) (
  input  logic                      clk_i_100mhz,
  input  logic                      sys_rst,
  input  logic [ADDR_WIDTH-1:0]     app_addr,
  input  logic [2:0]                app_cmd,
  input  logic                      app_en,
  output logic                      app_rdy,
  input  logic [APP_DATA_WIDTH-1:0] app_wdf_data,
  input  logic [APP_MASK_WIDTH-1:0] app_wdf_mask,
  input  logic                      app_wdf_wren,
  input  logic                      app_wdf_end,
  output logic                      app_wdf_rdy,
  output logic [APP_DATA_WIDTH-1:0] app_rd_data,
  output logic                      app_rd_data_valid,
  output logic                      app_rd_data_end,
  output logic                      init_calib_complete,
  output logic                      cmd_err
);

  localparam int MEM_DEPTH = 1 << MEM_DEPTH_LOG2;
  localparam int CAL_W     = $clog2(CALIB_CYCLES + 1);
  localparam logic [2:0] CMD_WRITE = 3'b000;
  localparam logic [2:0] CMD_READ  = 3'b001;

  typedef logic [MEM_DEPTH_LOG2-1:0] idx_t;

  typedef struct packed {
    logic [2:0] cmd;
    idx_t       idx;
  } cq_entry_t;

  typedef struct packed {
    logic [APP_DATA_WIDTH-1:0] data;
    logic [APP_MASK_WIDTH-1:0] mask;
  } wq_entry_t;

  // ---------------------------------------------------------------- calibration
  logic [CAL_W-1:0] calib_cnt;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk_i_100mhz or posedge sys_rst) begin
    if (sys_rst) begin
      calib_cnt           <= '0;
      init_calib_complete <= 1'b0;
    end else if (!init_calib_complete) begin
      calib_cnt <= calib_cnt + 1'b1;
      if (calib_cnt == CAL_W'(CALIB_CYCLES - 1)) init_calib_complete <= 1'b1;
    end
  end

  // ---------------------------------------------------------------- ready stall
  logic stall_pulse;

  if (RDY_STALL_PERIOD > 0) begin : g_stall
    localparam int STALL_W = (RDY_STALL_PERIOD > 1) ? $clog2(RDY_STALL_PERIOD) : 1;
    logic [STALL_W-1:0] stall_cnt;

    always_ff @(posedge clk_i_100mhz or posedge sys_rst) begin
      if (sys_rst)                                         stall_cnt <= '0;
      else if (stall_cnt == STALL_W'(RDY_STALL_PERIOD - 1)) stall_cnt <= '0;
      else                                                 stall_cnt <= stall_cnt + 1'b1;
    end

    assign stall_pulse = (stall_cnt == '0);
  end else begin : g_no_stall
    assign stall_pulse = 1'b0;
  end

  // ---------------------------------------------------------------- queues
  cq_entry_t  cq_mem [4];
  wq_entry_t  wq_mem [4];
  logic [1:0] cq_wr, cq_rd, wq_wr, wq_rd;
  logic [2:0] cq_count, wq_count;
  logic       cq_push, wq_push, cq_pop, wq_pop;

  // Ready is built from registered counts only: a full queue stays not-ready during a pop.
  assign app_rdy     = init_calib_complete && (cq_count < 3'd4) && !stall_pulse;
  assign app_wdf_rdy = init_calib_complete && (wq_count < 3'd4);
  assign cq_push     = app_en && app_rdy;
  assign wq_push     = app_wdf_wren && app_wdf_rdy;

  // NOTE: queue storage and the word array carry no reset; valid state lives in pointers and counts.
  always_ff @(posedge clk_i_100mhz) begin
    if (cq_push) cq_mem[cq_wr] <= '{cmd: app_cmd, idx: app_addr[MEM_DEPTH_LOG2+2:3]};
    if (wq_push) wq_mem[wq_wr] <= '{data: app_wdf_data, mask: app_wdf_mask};
  end

  always_ff @(posedge clk_i_100mhz or posedge sys_rst) begin
    if (sys_rst) begin
      cq_wr    <= '0;
      cq_rd    <= '0;
      cq_count <= '0;
      wq_wr    <= '0;
      wq_rd    <= '0;
      wq_count <= '0;
    end else begin
      if (cq_push) cq_wr <= cq_wr + 1'b1;
      if (cq_pop)  cq_rd <= cq_rd + 1'b1;
      if (wq_push) wq_wr <= wq_wr + 1'b1;
      if (wq_pop)  wq_rd <= wq_rd + 1'b1;
      cq_count <= cq_count + 3'(cq_push) - 3'(cq_pop);
      wq_count <= wq_count + 3'(wq_push) - 3'(wq_pop);
    end
  end

  // ---------------------------------------------------------------- executor
  cq_entry_t cq_head;
  wq_entry_t wq_head;
  logic      exec_write, exec_read, exec_illegal;

  assign cq_head = cq_mem[cq_rd];
  assign wq_head = wq_mem[wq_rd];

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    exec_write   = 1'b0;
    exec_read    = 1'b0;
    exec_illegal = 1'b0;
    if (cq_count != 3'd0) begin
      case (cq_head.cmd)
        CMD_WRITE: exec_write   = (wq_count != 3'd0);
        CMD_READ:  exec_read    = 1'b1;
        default:   exec_illegal = 1'b1;
      endcase
    end
  end

  assign cq_pop = exec_write || exec_read || exec_illegal;
  assign wq_pop = exec_write;

  always_ff @(posedge clk_i_100mhz or posedge sys_rst) begin
    if (sys_rst)           cmd_err <= 1'b0;
    else if (exec_illegal) cmd_err <= 1'b1;
  end

  // ---------------------------------------------------------------- word array
  logic [APP_DATA_WIDTH-1:0] mem [MEM_DEPTH];

  always_ff @(posedge clk_i_100mhz) begin
    if (exec_write) begin
      for (int b = 0; b < APP_MASK_WIDTH; b++) begin
        if (!wq_head.mask[b]) mem[cq_head.idx][8*b +: 8] <= wq_head.data[8*b +: 8];
      end
    end
  end

  // ---------------------------------------------------------------- read pipeline
  // Data stages only advance behind a valid beat, so the last stage holds the most recent read.
  logic [RD_LATENCY-1:0]     pipe_valid;
  logic [APP_DATA_WIDTH-1:0] pipe_data [RD_LATENCY];

  always_ff @(posedge clk_i_100mhz or posedge sys_rst) begin
    if (sys_rst) begin
      pipe_valid <= '0;
      for (int i = 0; i < RD_LATENCY; i++) pipe_data[i] <= '0;
    end else begin
      pipe_valid[0] <= exec_read;
      if (exec_read) pipe_data[0] <= mem[cq_head.idx];
      for (int i = 1; i < RD_LATENCY; i++) begin
        pipe_valid[i] <= pipe_valid[i-1];
        if (pipe_valid[i-1]) pipe_data[i] <= pipe_data[i-1];
      end
    end
  end

  assign app_rd_data       = pipe_data[RD_LATENCY-1];
  assign app_rd_data_valid = pipe_valid[RD_LATENCY-1];
  assign app_rd_data_end   = pipe_valid[RD_LATENCY-1];

  // Address bits outside the word index and the redundant end strobe carry no information.
  logic unused_inputs;
  assign unused_inputs = ^{app_wdf_end, app_addr[2:0], app_addr[ADDR_WIDTH-1:MEM_DEPTH_LOG2+3]};

endmodule

// File: tb/tb_mig_ui_responder.sv
// Self-checking bench for mig_ui_responder: directed phases plus a random write/read mix
// scored against an in-order word-array model; a second instance exercises ready stalls.
module tb_mig_ui_responder;

  localparam int AW  = 29;
  localparam int DW  = 128;
  localparam int MW  = 16;
  localparam int DL  = 10;
  localparam int CAL = 64;
  localparam int RL  = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          sys_rst;
  logic [AW-1:0] app_addr;
  logic [2:0]    app_cmd;
  logic          app_en, app_rdy;
  logic [DW-1:0] app_wdf_data;
  logic [MW-1:0] app_wdf_mask;
  logic          app_wdf_wren, app_wdf_end, app_wdf_rdy;
  logic [DW-1:0] rd_data;
  logic          rd_valid, rd_end, calib, cmd_err;

  logic [AW-1:0] s_addr;
  logic [2:0]    s_cmd;
  logic          s_en, s_rdy, s_wdf_rdy, s_valid, s_end, s_calib, s_cmd_err;
  logic [DW-1:0] s_rd_data;

  mig_ui_responder #(.CALIB_CYCLES(CAL), .RD_LATENCY(RL), .RDY_STALL_PERIOD(0)) dut (
    .clk_i_100mhz(clk), .sys_rst(sys_rst),
    .app_addr(app_addr), .app_cmd(app_cmd), .app_en(app_en), .app_rdy(app_rdy),
    .app_wdf_data(app_wdf_data), .app_wdf_mask(app_wdf_mask), .app_wdf_wren(app_wdf_wren),
    .app_wdf_end(app_wdf_end), .app_wdf_rdy(app_wdf_rdy),
    .app_rd_data(rd_data), .app_rd_data_valid(rd_valid), .app_rd_data_end(rd_end),
    .init_calib_complete(calib), .cmd_err(cmd_err)
  );

  mig_ui_responder #(.CALIB_CYCLES(CAL), .RD_LATENCY(RL), .RDY_STALL_PERIOD(4)) s_dut (
    .clk_i_100mhz(clk), .sys_rst(sys_rst),
    .app_addr(s_addr), .app_cmd(s_cmd), .app_en(s_en), .app_rdy(s_rdy),
    .app_wdf_data('0), .app_wdf_mask('0), .app_wdf_wren(1'b0),
    .app_wdf_end(1'b0), .app_wdf_rdy(s_wdf_rdy),
    .app_rd_data(s_rd_data), .app_rd_data_valid(s_valid), .app_rd_data_end(s_end),
    .init_calib_complete(s_calib), .cmd_err(s_cmd_err)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int s_beats  = 0;

  logic [DW-1:0] got_d [$];
  int            got_c [$];
  logic [DW-1:0] exp_q [$];
  logic [DW-1:0] m_mem [1 << DL];

  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rd_valid) begin
      got_d.push_back(rd_data);
      got_c.push_back(cyc);
    end
    if (rd_valid || rd_end) check("rd_end_tracks_valid", rd_end, rd_valid);
    if (s_valid) s_beats <= s_beats + 1;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int idx_of(input logic [AW-1:0] a);
    return int'(a[DL+2:3]);
  endfunction

  function automatic logic [AW-1:0] addr_for(input int idx);
    logic [AW-1:0] a;
    a = AW'($urandom);
    a[DL+2:3] = DL'(idx);
    return a;
  endfunction

  function automatic void m_apply(input int idx, input logic [DW-1:0] d, input logic [MW-1:0] m);
    for (int b = 0; b < MW; b++) if (!m[b]) m_mem[idx][8*b +: 8] = d[8*b +: 8];
  endfunction

  task automatic issue(input logic [2:0] cmd, input logic [AW-1:0] addr, output int acc_cyc);
    bit ok = 1'b0;
    app_cmd  = cmd;
    app_addr = addr;
    app_en   = 1'b1;
    for (int i = 0; i < 300 && !ok; i++) begin
      ok = app_rdy;
      tick();
    end
    app_en  = 1'b0;
    acc_cyc = cyc;
    check("cmd_accepted", ok, 1'b1);
  endtask

  task automatic push_data(input logic [DW-1:0] d, input logic [MW-1:0] m);
    bit ok = 1'b0;
    app_wdf_data = d;
    app_wdf_mask = m;
    app_wdf_wren = 1'b1;
    app_wdf_end  = 1'b1;
    for (int i = 0; i < 300 && !ok; i++) begin
      ok = app_wdf_rdy;
      tick();
    end
    app_wdf_wren = 1'b0;
    app_wdf_end  = 1'b0;
    check("wdata_accepted", ok, 1'b1);
  endtask

  task automatic wr(input logic [AW-1:0] addr, input logic [DW-1:0] d, input logic [MW-1:0] m);
    int c;
    push_data(d, m);
    issue(3'b000, addr, c);
    m_apply(idx_of(addr), d, m);
  endtask

  task automatic rd(input logic [AW-1:0] addr, output int c);
    issue(3'b001, addr, c);
    exp_q.push_back(m_mem[idx_of(addr)]);
  endtask

  task automatic drain_compare(input string tag);
    int n;
    for (int i = 0; i < 400 && got_d.size() < exp_q.size(); i++) tick();
    repeat (RL + 4) tick();
    check({tag, "_beat_count"}, got_d.size(), exp_q.size());
    n = (got_d.size() < exp_q.size()) ? got_d.size() : exp_q.size();
    for (int i = 0; i < n; i++) check({tag, "_data"}, got_d[i], exp_q[i]);
    got_d.delete();
    got_c.delete();
    exp_q.delete();
  endtask

  initial begin
    #10000000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [DW-1:0] d0, last_d;
    int c1, c2, acc, lows, last_low, s_acc;
    bit r, seen;

    sys_rst = 1'b1;
    app_addr = '0; app_cmd = 3'b001; app_en = 1'b0;
    app_wdf_data = '0; app_wdf_mask = '0; app_wdf_wren = 1'b0; app_wdf_end = 1'b0;
    s_addr = '0; s_cmd = 3'b001; s_en = 1'b0;
    repeat (3) tick();

    // Reset values
    check("rst_app_rdy", app_rdy, 1'b0);
    check("rst_wdf_rdy", app_wdf_rdy, 1'b0);
    check("rst_rd_data", rd_data, '0);
    check("rst_rd_valid", rd_valid, 1'b0);
    check("rst_rd_end", rd_end, 1'b0);
    check("rst_calib", calib, 1'b0);
    check("rst_cmd_err", cmd_err, 1'b0);

    // Calibration: a read held on app_en before calibration must never be taken
    app_en  = 1'b1;
    app_cmd = 3'b001;
    sys_rst = 1'b0;
    repeat (CAL - 1) tick();
    check("calib_edge63", calib, 1'b0);
    check("rdy_edge63", app_rdy, 1'b0);
    check("wdf_rdy_edge63", app_wdf_rdy, 1'b0);
    tick();
    app_en = 1'b0;
    check("calib_edge64", calib, 1'b1);
    check("rdy_edge64", app_rdy, 1'b1);
    check("wdf_rdy_edge64", app_wdf_rdy, 1'b1);
    repeat (RL + 8) tick();
    check("early_cmd_ignored", got_d.size(), 0);

    // Write then read, latency, wrap-around and back-to-back
    d0 = 128'h0123_4567_89AB_CDEF_0123_4567_89AB_CDEF;
    wr(AW'(8), d0, '0);
    rd(AW'(8), c1);
    rd(AW'(8 + 8 * (1 << DL)), c2);
    check("b2b_accept", c2, c1 + 1);
    repeat (RL + 4) tick();
    if (got_c.size() >= 2) begin
      check("rd_latency", got_c[0], c1 + RL);
      check("rd_no_bubble", got_c[1], got_c[0] + 1);
      check("wr_rd_value", got_d[0], d0);
      check("wrap_value", got_d[1], d0);
    end
    check("rd_data_hold", rd_data, d0);
    drain_compare("wr_rd");

    // Byte mask: upper eight bytes masked off, lower eight written with zero
    wr(AW'(16 * 8), {DW{1'b1}}, '0);
    wr(AW'(16 * 8), '0, 16'hFF00);
    rd(AW'(16 * 8), c1);
    repeat (RL + 4) tick();
    if (got_d.size() >= 1) check("mask_value", got_d[0], {64'hFFFF_FFFF_FFFF_FFFF, 64'h0});
    drain_compare("mask");

    // Command queue full with write data late
    acc = 0;
    app_cmd  = 3'b000;
    app_addr = AW'(32 * 8);
    app_en   = 1'b1;
    for (int i = 0; i < 40 && acc < 4; i++) begin
      if (app_rdy) acc++;
      tick();
    end
    check("cq_four_accepted", acc, 4);
    repeat (3) begin
      check("cq_full_not_ready", app_rdy, 1'b0);
      tick();
    end
    app_en = 1'b0;
    for (int i = 0; i < 4; i++) begin
      last_d = {$urandom, $urandom, $urandom, $urandom};
      push_data(last_d, '0);
      m_apply(32, last_d, '0);
    end
    last_d = {$urandom, $urandom, $urandom, $urandom};
    wr(AW'(32 * 8), last_d, '0);
    rd(AW'(32 * 8), c1);
    repeat (RL + 4) tick();
    if (got_d.size() >= 1) check("late_last_value", got_d[0], last_d);
    drain_compare("late");

    // Illegal command
    issue(3'b010, AW'(8), c1);
    repeat (3) tick();
    check("illegal_cmd_err", cmd_err, 1'b1);
    repeat (RL + 4) tick();
    check("illegal_no_data", got_d.size(), 0);

    // Stall instance: continuous reads, ready low exactly one cycle in four
    lows = 0; last_low = -1; s_acc = 0;
    s_en = 1'b1;
    for (int i = 0; i < 40; i++) begin
      r = s_rdy;
      if (!r) begin
        lows++;
        if (last_low >= 0) check("stall_period", i - last_low, 4);
        last_low = i;
      end else begin
        s_acc++;
      end
      tick();
    end
    s_en = 1'b0;
    check("stall_low_count", lows, 10);
    repeat (RL + 6) tick();
    check("stall_no_loss", s_beats, s_acc);

    // Random mix against the model
    for (int i = 0; i < 16; i++) wr(addr_for(100 + i), {$urandom, $urandom, $urandom, $urandom}, '0);
    for (int i = 0; i < 60; i++) begin
      if ($urandom_range(0, 1) == 1)
        wr(addr_for(100 + $urandom_range(0, 15)), {$urandom, $urandom, $urandom, $urandom}, MW'($urandom));
      else
        rd(addr_for(100 + $urandom_range(0, 15)), c1);
    end
    drain_compare("rand");

    // Mid-operation reset with reads in flight
    rd(AW'(8), c1);
    rd(AW'(8), c1);
    rd(AW'(8), c1);
    exp_q.delete();
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      if (rd_valid) seen = 1'b1;
      else tick();
    end
    check("inflight_seen", seen, 1'b1);
    sys_rst = 1'b1;
    #1;
    check("rst_valid_drop", rd_valid, 1'b0);
    check("rst_rdy_drop", app_rdy, 1'b0);
    check("rst_calib_drop", calib, 1'b0);
    check("rst_cmd_err_clear", cmd_err, 1'b0);
    tick();
    got_d.delete();
    got_c.delete();
    tick();
    sys_rst = 1'b0;
    repeat (CAL + RL + 5) tick();
    check("no_stale_beats", got_d.size(), 0);
    check("recalibrated", calib, 1'b1);
    rd(AW'(8), c1);
    drain_compare("post_rst");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
